// File: rtl/key_event_ctrl.sv
// Front-panel key event controller: per-key press classifier (short/long/repeat/release)
// feeding a round-robin arbiter onto a single valid/ready event port.
module key_event_ctrl #(
    parameter int NUM_KEYS = 4,
    parameter int CNT_W    = 26,
    parameter int LONG_CNT = 25000000,
    parameter int REP_CNT  = 5000000,
    localparam int KW      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                FPGA_CLK,
    input  logic                FPGA_RST,
    input  logic [NUM_KEYS-1:0] KEY_LVL,
    input  logic                EVT_READY,
    input  logic                OVF_CLR,
    output logic                EVT_VALID,
    output logic [KW-1:0]       EVT_KEY,
    output logic [1:0]          EVT_TYPE,
    output logic [NUM_KEYS-1:0] KEY_BUSY,
    output logic [NUM_KEYS-1:0] OVF
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_RPT  = 2'd2
    } key_state_t;

    typedef enum logic [1:0] {
        EV_SHORT   = 2'd0,
        EV_LONG    = 2'd1,
        EV_REPEAT  = 2'd2,
        EV_RELEASE = 2'd3
    } evt_type_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CNT - 1);

    key_state_t          state_q   [NUM_KEYS];
    key_state_t          state_d   [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_q     [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d     [NUM_KEYS];
    evt_type_t           post_type [NUM_KEYS];
    logic [1:0]          ptype_q   [NUM_KEYS];
    logic [NUM_KEYS-1:0] post;
    logic [NUM_KEYS-1:0] pend_q;
    logic [NUM_KEYS-1:0] consume;
    logic [KW-1:0]       rr_q;
    logic [KW-1:0]       rr_next;
    logic [KW-1:0]       winner;
    logic [KW-1:0]       sel;
    logic                found;
    logic                slot_free;

    // Per-key classifier; the counter is bounded by the compares, so it never wraps.
    always_comb begin
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            post[i]      = 1'b0;
            post_type[i] = EV_SHORT;
            case (state_q[i])
                ST_IDLE: begin
                    if (KEY_LVL[i]) begin
                        state_d[i] = ST_HELD;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!KEY_LVL[i]) begin
                        post[i]      = 1'b1;
                        post_type[i] = EV_SHORT;
                        state_d[i]   = ST_IDLE;
                        cnt_d[i]     = '0;
                    end else if (cnt_q[i] == LONG_LAST) begin
                        post[i]      = 1'b1;
                        post_type[i] = EV_LONG;
                        state_d[i]   = ST_RPT;
                        cnt_d[i]     = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ST_RPT: begin
                    if (!KEY_LVL[i]) begin
                        post[i]      = 1'b1;
                        post_type[i] = EV_RELEASE;
                        state_d[i]   = ST_IDLE;
                        cnt_d[i]     = '0;
                    end else if (cnt_q[i] == REP_LAST) begin
                        post[i]      = 1'b1;
                        post_type[i] = EV_REPEAT;
                        cnt_d[i]     = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge FPGA_CLK) begin
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (FPGA_RST) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            KEY_BUSY[i] = (state_q[i] != ST_IDLE);
        end
    end

    // Round-robin search: first pending key at or above rr, wrapping.
    always_comb begin
        slot_free = !EVT_VALID || EVT_READY;
        found     = 1'b0;
        winner    = '0;
        sel       = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            sel = KW'((32'(rr_q) + k) % NUM_KEYS);
            if (!found && pend_q[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
        consume = '0;
        if (slot_free && found) begin
            consume[winner] = 1'b1;
        end
        rr_next = (winner == KW'(NUM_KEYS - 1)) ? '0 : winner + KW'(1);
    end

    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            pend_q    <= '0;
            OVF       <= '0;
            rr_q      <= '0;
            EVT_VALID <= 1'b0;
            EVT_KEY   <= '0;
            EVT_TYPE  <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                ptype_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if (post[i]) begin
                    pend_q[i]  <= 1'b1;
                    ptype_q[i] <= post_type[i];
                end else if (consume[i]) begin
                    pend_q[i] <= 1'b0;
                end
                // A lost event outranks a simultaneous clear.
                if (post[i] && pend_q[i] && !consume[i]) begin
                    OVF[i] <= 1'b1;
                end else if (OVF_CLR) begin
                    OVF[i] <= 1'b0;
                end
            end
            if (slot_free) begin
                if (found) begin
                    EVT_VALID <= 1'b1;
                    EVT_KEY   <= winner;
                    EVT_TYPE  <= ptype_q[winner];
                    rr_q      <= rr_next;
                end else begin
                    EVT_VALID <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: expected events queued as stimulus is driven,
// popped and compared (key, type, arrival edge) on every handshake.
module tb_key_event_ctrl;

    localparam int NK = 4;
    localparam int KW = 2;

    logic          clk;
    logic          rst;
    logic [NK-1:0] key_lvl;
    logic          evt_ready;
    logic          ovf_clr;
    logic          evt_valid;
    logic [KW-1:0] evt_key;
    logic [1:0]    evt_type;
    logic [NK-1:0] key_busy;
    logic [NK-1:0] ovf;

    typedef struct {
        int key;
        int typ;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ecnt   = 0;

    key_event_ctrl #(
        .NUM_KEYS(NK),
        .CNT_W(8),
        .LONG_CNT(10),
        .REP_CNT(4)
    ) dut (
        .FPGA_CLK(clk),
        .FPGA_RST(rst),
        .KEY_LVL(key_lvl),
        .EVT_READY(evt_ready),
        .OVF_CLR(ovf_clr),
        .EVT_VALID(evt_valid),
        .EVT_KEY(evt_key),
        .EVT_TYPE(evt_type),
        .KEY_BUSY(key_busy),
        .OVF(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares any handshake about to happen, then advances one clock; returns at negedge.
    task automatic tick();
        exp_t e;
        if (evt_valid && evt_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got key=%0d type=%0d at edge %0d, required no event",
                         evt_key, evt_type, ecnt);
            end else begin
                e = sb.pop_front();
                if (evt_key !== KW'(e.key) || evt_type !== 2'(e.typ) || (e.cyc >= 0 && ecnt != e.cyc)) begin
                    errors++;
                    $display("FAIL event: got key=%0d type=%0d edge=%0d, required key=%0d type=%0d edge=%0d",
                             evt_key, evt_type, ecnt, e.key, e.typ, e.cyc);
                end
            end
        end
        @(posedge clk);
        ecnt++;
        @(negedge clk);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        evt_ready = 1'b1;
        while (sb.size() > 0 && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d events outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        checks++;
        if ({evt_valid, evt_key, evt_type, key_busy, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b key=%0d type=%0d busy=%b ovf=%b, required all 0",
                     evt_valid, evt_key, evt_type, key_busy, ovf);
        end
    endtask

    task automatic test_short();
        int e0 = ecnt;
        int busy = 0;
        int vcnt = 0;
        sb.push_back('{0, 0, e0 + 7});
        key_lvl = 4'b0001;
        repeat (5) begin
            tick();
            if (key_busy[0]) busy++;
            if (evt_valid) vcnt++;
        end
        key_lvl = 4'b0000;
        repeat (5) begin
            tick();
            if (key_busy[0]) busy++;
            if (evt_valid) vcnt++;
        end
        checks++;
        if (busy != 5) begin
            errors++;
            $display("FAIL short_busy: got %0d busy cycles, required 5", busy);
        end
        checks++;
        if (vcnt != 1) begin
            errors++;
            $display("FAIL short_valid_len: got %0d valid cycles, required 1", vcnt);
        end
        drain(5);
    endtask

    task automatic test_long();
        int e0 = ecnt;
        sb.push_back('{1, 1, e0 + 11});
        sb.push_back('{1, 2, e0 + 15});
        sb.push_back('{1, 2, e0 + 19});
        sb.push_back('{1, 3, e0 + 22});
        key_lvl = 4'b0010;
        repeat (20) tick();
        key_lvl = 4'b0000;
        drain(10);
    endtask

    task automatic test_round_robin();
        int e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            key_lvl = 4'b1101;
            repeat (3) tick();
            e = ecnt;
            key_lvl = 4'b0000;
            sb.push_back('{0, 0, e + 2});
            sb.push_back('{2, 0, e + 3});
            sb.push_back('{3, 0, e + 4});
            drain(10);
        end
    endtask

    task automatic test_overflow();
        evt_ready = 1'b0;
        sb.push_back('{2, 0, -1});
        sb.push_back('{2, 0, -1});
        for (int p = 0; p < 3; p++) begin
            key_lvl[2] = 1'b1;
            repeat (2) tick();
            key_lvl[2] = 1'b0;
            repeat (2) begin
                tick();
                if (evt_valid) begin
                    checks++;
                    if (evt_key !== 2'd2 || evt_type !== 2'd0) begin
                        errors++;
                        $display("FAIL stall_stable: got key=%0d type=%0d, required key=2 type=0", evt_key, evt_type);
                    end
                end
            end
        end
        checks++;
        if (evt_valid !== 1'b1 || ovf !== 4'b0100) begin
            errors++;
            $display("FAIL ovf_set: got valid=%b ovf=%b, required valid=1 ovf=0100", evt_valid, ovf);
        end
        drain(10);
        checks++;
        if (ovf !== 4'b0100) begin
            errors++;
            $display("FAIL ovf_sticky: got %b, required 0100", ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_clear: got %b, required 0000", ovf);
        end
    endtask

    task automatic test_reset_mid_hold();
        int r;
        key_lvl = 4'b0010;
        repeat (7) tick();
        checks++;
        if (key_busy !== 4'b0010) begin
            errors++;
            $display("FAIL pre_reset_busy: got %b, required 0010", key_busy);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({evt_valid, evt_key, evt_type, key_busy, ovf} !== '0) begin
            errors++;
            $display("FAIL mid_reset_state: got valid=%b key=%0d type=%0d busy=%b ovf=%b, required all 0",
                     evt_valid, evt_key, evt_type, key_busy, ovf);
        end
        rst = 1'b0;
        r = ecnt;
        sb.push_back('{1, 1, r + 11});
        sb.push_back('{1, 3, -1});
        repeat (11) tick();
        key_lvl = 4'b0000;
        drain(10);
    endtask

    task automatic test_ovf_clr_collision();
        evt_ready = 1'b0;
        sb.push_back('{3, 0, -1});
        sb.push_back('{3, 0, -1});
        for (int p = 0; p < 3; p++) begin
            key_lvl[3] = 1'b1;
            repeat (2) tick();
            if (p == 2) begin
                checks++;
                if (ovf[3] !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early: got %b, required 0", ovf[3]);
                end
                ovf_clr = 1'b1;
            end
            key_lvl[3] = 1'b0;
            tick();
            ovf_clr = 1'b0;
            tick();
        end
        checks++;
        if (ovf !== 4'b1000) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b, required 1000", ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_clr_alone: got %b, required 0000", ovf);
        end
        drain(10);
    endtask

    initial begin
        rst       = 1'b1;
        key_lvl   = '0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        @(negedge clk);
        test_reset();
        test_short();
        test_long();
        test_round_robin();
        test_overflow();
        test_reset_mid_hold();
        test_ovf_clr_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
Front-panel key event controller. Takes the debounced, active-high levels of NUM_KEYS keys (one debouncer per key upstream). A per-key state machine classifies each press as short, long, auto-repeat or release-after-long. A round-robin arbiter then serialises the resulting events onto a single valid/ready event port for the control logic downstream.

Parameters:
NUM_KEYS, 4, number of key inputs (>=2)
CNT_W, 26, width of the per-key hold counters
LONG_CNT, 25000000, consecutive pressed cycles that define a long press (0.5 s at 50 MHz), >=2
REP_CNT, 5000000, cycles between auto-repeat events after a long press, >=2
KW (localparam), max(1, clog2(NUM_KEYS)), width of the key index

Ports:
FPGA_CLK  in  1  system clock; all logic on the rising edge
FPGA_RST  in  1  reset, synchronous, active-high
KEY_LVL  in  NUM_KEYS  debounced key levels, 1 = pressed
EVT_READY  in  1  consumer accepts the event on this cycle
OVF_CLR  in  1  single-cycle pulse that clears OVF
EVT_VALID  out  1  event present on EVT_KEY/EVT_TYPE
EVT_KEY  out  KW  index of the key that produced the event
EVT_TYPE  out  2  0=SHORT, 1=LONG, 2=REPEAT, 3=RELEASE
KEY_BUSY  out  NUM_KEYS  per-key FSM not in IDLE
OVF  out  NUM_KEYS  sticky per-key event-lost flags

Behaviour:
- Reset (FPGA_RST=1 at an edge):
  - EVT_VALID, EVT_KEY, EVT_TYPE, KEY_BUSY and OVF all go to 0.
  - All FSMs go to IDLE, counters to 0, pending flags to 0, round-robin pointer to 0.
  - Reset overrides every other input.
  - A key still held when reset is released is treated as a new press from the first post-reset cycle.
- Per-key FSM (one instance per key, index i, counter cnt):
  - IDLE: KEY_LVL=1 -> HELD, cnt<=1. Otherwise stay in IDLE.
  - HELD, KEY_LVL=0 -> post SHORT, go to IDLE, cnt<=0.
  - HELD, KEY_LVL=1 and cnt==LONG_CNT-1 -> post LONG, go to RPT, cnt<=0. LONG is therefore posted on the LONG_CNT-th consecutive pressed cycle.
  - HELD, KEY_LVL=1 otherwise -> cnt++.
  - RPT, KEY_LVL=0 -> post RELEASE, go to IDLE, cnt<=0.
  - RPT, KEY_LVL=1 and cnt==REP_CNT-1 -> post REPEAT, cnt<=0.
  - RPT, KEY_LVL=1 otherwise -> cnt++.
  - The counter never wraps; it is bounded by the compares above.
  - KEY_BUSY[i]=1 in HELD or RPT, registered with the state.
- Posting:
  - A post sets pend[i] and ptype[i] at the same edge.
  - If pend[i] is already set and is not being consumed that cycle, ptype[i] is overwritten (newest event wins) and OVF[i] is set.
  - If pend[i] is consumed by the arbiter in the same cycle as a new post, pend[i] stays set with the new type and OVF is not set.
- Output slot and arbitration:
  - The slot is free when EVT_VALID=0 or (EVT_VALID & EVT_READY).
  - When the slot is free and any pend is set, the arbiter selects the first pending index starting at rr and going upward with wrap.
  - The selected event is loaded into EVT_KEY/EVT_TYPE, EVT_VALID<=1, the winner's pend is cleared, and rr<=(winner+1) mod NUM_KEYS.
  - When the slot is free and nothing is pending, EVT_VALID<=0.
- Latency: a post at edge t gives EVT_VALID=1 at edge t+1 at the earliest. With READY held at 1 the port sustains one event per cycle.
- Handshake:
  - While EVT_VALID=1 and EVT_READY=0, EVT_KEY and EVT_TYPE are stable.
  - EVT_VALID never drops without a handshake.
  - EVT_READY has no effect while EVT_VALID=0.
- OVF[i] is cleared by OVF_CLR. If a set and OVF_CLR occur in the same cycle, the set wins.
- Each key holds at most one pending event plus the output slot. There is no deeper buffering.

Test Plan:
All scenarios use NUM_KEYS=4, LONG_CNT=10, REP_CNT=4.
1. Short press: key0 high for 5 cycles then low, READY=1 -> exactly one event {key0, SHORT}; EVT_VALID high 1 cycle, asserted the edge after the release is sampled; KEY_BUSY[0] high for 5 cycles.
2. Long hold: key1 high for 20 cycles then low, READY=1 -> events in order:
   - {1, LONG} on pressed cycle 10
   - {1, REPEAT} on cycle 14
   - {1, REPEAT} on cycle 18
   - {1, RELEASE} after the release
   - no SHORT event.
3. Round-robin: keys 0, 2 and 3 released in the same cycle (each after a short press), READY=1 -> {0,SHORT}, {2,SHORT}, {3,SHORT} on consecutive cycles. A repeat of the same stimulus then starts at key0 again (rr=0 after the wrap).
4. Backpressure/overflow: READY=0, key2 gives three short presses ->
   - first SHORT held stable on the port
   - second SHORT pending
   - third press overwrites the pending event and sets OVF[2]=1
   - READY=1 then delivers exactly two events
   - OVF[2] stays 1 until OVF_CLR.
5. Reset mid-hold: key1 held for 7 cycles, FPGA_RST pulsed for 1 cycle, key1 kept high -> all outputs 0 after the reset edge; LONG appears only on the 10th pressed cycle after reset is released.
6. OVF_CLR in the same cycle as a new overflow on key3 -> OVF[3] remains 1; OVF_CLR alone on a later cycle clears it to 0.
